// File: rtl/ad9866_ctrl_arb_if.sv
// Register-write traffic around the AD9866 control arbiter: gain levels and
// host writes coming in, SPI frame launch/handshake going out.
interface ad9866_ctrl_arb_if;
    logic [5:0]  rx_gain;
    logic [3:0]  tx_gain;
    logic        host_req;
    logic [4:0]  host_addr;
    logic [7:0]  host_data;
    logic        host_ack;
    logic        spi_start;
    logic [15:0] spi_word;
    logic        spi_busy;
    logic        spi_err;

    // Requesting side: host, gain sources and the SPI engine status.
    modport master (
        output rx_gain, tx_gain, host_req, host_addr, host_data, spi_busy,
        input  host_ack, spi_start, spi_word, spi_err
    );

    // Arbiter side.
    modport slave (
        input  rx_gain, tx_gain, host_req, host_addr, host_data, spi_busy,
        output host_ack, spi_start, spi_word, spi_err
    );
endinterface

// File: rtl/ad9866_ctrl_arb.sv
// AD9866 control-register arbiter: round-robin between host writes, RX gain
// updates and TX gain updates, launching one 16-bit SPI frame at a time with
// a busy timeout and an enforced idle gap between frames.
module ad9866_ctrl_arb #(
    parameter logic [4:0] RX_GAIN_ADDR = 5'h09,
    parameter logic [4:0] TX_GAIN_ADDR = 5'h0a,
    parameter int         GAP_CYCLES   = 4,
    parameter int         TIMEOUT      = 16
) (
    input logic              clk,
    input logic              reset_n,
    ad9866_ctrl_arb_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    localparam logic [1:0] SRC_HOST     = 2'd0;
    localparam logic [1:0] SRC_RX       = 2'd1;
    localparam logic [1:0] SRC_TX       = 2'd2;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST     = 8'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_n;
    logic [7:0]  cnt;
    logic [1:0]  last_grant;
    logic [1:0]  cur_src;
    logic [1:0]  grant_src;
    logic [15:0] word_q;
    logic [15:0] grant_word;
    logic [5:0]  rx_sent;
    logic        rx_sent_vld;
    logic [3:0]  tx_sent;
    logic        tx_sent_vld;
    logic        host_acked;
    logic [2:0]  live;
    logic [2:0]  pend_q;
    logic [2:0]  elig;
    logic        grant;
    logic        timeout;

    // Pick the first requester after the last granted one (0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        case (last)
            2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (req[first])       rr_pick = first;
        else if (req[second]) rr_pick = second;
        else                  rr_pick = third;
    endfunction

    // A source is eligible only when its request was seen last cycle and is
    // still present now, so a host request withdrawn before grant is dropped
    // and a gain that returns to its sent value issues nothing.
    assign live[0] = bus.host_req & ~host_acked;
    assign live[1] = ~rx_sent_vld | (bus.rx_gain != rx_sent);
    assign live[2] = ~tx_sent_vld | (bus.tx_gain != tx_sent);
    assign elig    = live & pend_q;

    assign grant_src    = rr_pick(elig, last_grant);
    assign bus.spi_word = word_q;

    // Frame contents for the source that would win this cycle.
    always_comb begin
        grant_word = 16'h0000;
        case (grant_src)
            SRC_HOST: grant_word = {3'b000, bus.host_addr, bus.host_data};
            SRC_RX:   grant_word = {3'b000, RX_GAIN_ADDR, 2'b01, bus.rx_gain};
            default:  grant_word = {3'b000, TX_GAIN_ADDR, 4'b0000, bus.tx_gain};
        endcase
    end

    // Next-state and strobe decode of the frame sequencer.
    always_comb begin
        state_n       = state;
        grant         = 1'b0;
        timeout       = 1'b0;
        bus.spi_start = 1'b0;
        bus.host_ack  = 1'b0;
        bus.spi_err   = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    grant        = 1'b1;
                    bus.host_ack = (grant_src == SRC_HOST);
                    state_n      = ISSUE;
                end
            end
            ISSUE: begin
                bus.spi_start = 1'b1;
                state_n       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.spi_busy) begin
                    state_n = WAIT_DONE;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout     = 1'b1;
                    bus.spi_err = 1'b1;
                    state_n     = GAP;
                end
            end
            WAIT_DONE: begin
                if (!bus.spi_busy) state_n = GAP;
            end
            GAP: begin
                if (cnt == GAP_LAST) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; cnt counts cycles spent in the current state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? 8'd0 : cnt + 8'd1;
        end
    end

    // Arbitration bookkeeping: pending flags, grant history, latched frame
    // and the valid flags that force a gain rewrite after reset or timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= 3'b000;
            host_acked  <= 1'b0;
            word_q      <= 16'h0000;
            last_grant  <= SRC_TX;
            cur_src     <= SRC_HOST;
            rx_sent_vld <= 1'b0;
            tx_sent_vld <= 1'b0;
        end else begin
            pend_q <= live;
            if (!bus.host_req)                      host_acked <= 1'b0;
            else if (grant && grant_src == SRC_HOST) host_acked <= 1'b1;
            if (grant) begin
                word_q     <= grant_word;
                last_grant <= grant_src;
                cur_src    <= grant_src;
                if (grant_src == SRC_RX) rx_sent_vld <= 1'b1;
                if (grant_src == SRC_TX) tx_sent_vld <= 1'b1;
            end
            if (timeout) begin
                if (cur_src == SRC_RX) rx_sent_vld <= 1'b0;
                if (cur_src == SRC_TX) tx_sent_vld <= 1'b0;
            end
        end
    end

    // Last-sent gain values; only meaningful while their valid flag is set.
    always_ff @(posedge clk) begin
        if (grant && grant_src == SRC_RX) rx_sent <= bus.rx_gain;
        if (grant && grant_src == SRC_TX) tx_sent <= bus.tx_gain;
    end

endmodule

// File: doc/ad9866_ctrl_arb.md
AD9866_CTRL_ARB -- requirements
Module: ad9866_ctrl_arb

Interface
REQ-001 Parameter RX_GAIN_ADDR, default 5'h09, AD9866 register address for RX gain writes.
REQ-002 Parameter TX_GAIN_ADDR, default 5'h0a, AD9866 register address for TX gain writes.
REQ-003 Parameter GAP_CYCLES, default 4, idle clk cycles enforced between consecutive frames (range 1..15).
REQ-004 Parameter TIMEOUT, default 16, max clk cycles waiting for spi_busy to rise after spi_start (range 2..255).
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 reset_n  input  1  reset, asynchronous and active-low.
REQ-007 rx_gain  input  6  requested RX PGA gain code, level signal.
REQ-008 tx_gain  input  4  requested TX gain code, level signal.
REQ-009 host_req  input  1  host register write request, held high until host_ack.
REQ-010 host_addr  input  5  host write register address, stable while host_req high.
REQ-011 host_data  input  8  host write data, stable while host_req high.
REQ-012 host_ack  output  1  one-cycle pulse: host request accepted.
REQ-013 spi_start  output  1  one-cycle pulse to SPI engine: launch frame.
REQ-014 spi_word  output  16  frame {3'b000, addr[4:0], data[7:0]}, held stable from spi_start until return to IDLE.
REQ-015 spi_busy  input  1  high while SPI engine shifts a frame.
REQ-016 spi_err  output  1  one-cycle pulse: spi_busy timeout.

Function
REQ-017 Sources: 0 = host, 1 = RX gain, 2 = TX gain; each has a pending flag.
REQ-018 Host pending = host_req high and not acked in the current transaction.
REQ-019 RX pending set when rx_gain != rx_sent (last-sent register); TX likewise with tx_sent.
REQ-020 Gain changes while a gain frame is in flight coalesce; only the value present at grant is sent.
REQ-021 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
REQ-022 IDLE: if any source pending, grant by round-robin starting at the source after last_grant; go to ISSUE next cycle.
REQ-023 At grant: latch spi_word; host -> {3'b000,host_addr,host_data} and host_ack pulses the same cycle; RX -> {3'b000,RX_GAIN_ADDR,2'b01,rx_gain}, rx_sent <= rx_gain; TX -> {3'b000,TX_GAIN_ADDR,4'b0000,tx_gain}, tx_sent <= tx_gain.
REQ-024 last_grant updates to the granted source at grant.
REQ-025 ISSUE: spi_start high exactly one cycle; go to WAIT_BUSY; timeout counter cleared.
REQ-026 WAIT_BUSY: spi_busy high -> WAIT_DONE; counter reaching TIMEOUT without busy -> spi_err pulse, go to GAP.
REQ-027 On timeout of a gain frame, the matching *_sent register is invalidated so the write is retried; a host frame is not retried.
REQ-028 WAIT_DONE: spi_busy low -> GAP.
REQ-029 GAP: count GAP_CYCLES cycles, then IDLE; no grant during GAP.
REQ-030 Latency: pending source in IDLE with nothing else pending -> spi_start 2 cycles later.
REQ-031 spi_start never asserts outside ISSUE; at most one frame outstanding.
REQ-032 host_req dropped before ack: request discarded, no frame.

Reset
REQ-033 reset_n low: state IDLE, spi_start 0, host_ack 0, spi_err 0, spi_word 16'h0000, last_grant 2 (host first after reset), counters 0.
REQ-034 reset_n low: rx_sent and tx_sent marked invalid, so current rx_gain and tx_gain are written after reset release.
REQ-035 Reset mid-frame abandons the frame; no spi_start or host_ack until reset_n high.

Verification
REQ-036 Release reset, rx_gain=6'h15, tx_gain=4'h3, no host -> RX frame 16'h0955 then TX frame 16'h0a03, separated by >=GAP_CYCLES+2 cycles.
REQ-037 host_req with addr 5'h07, data 8'h21, plus rx_gain change, same cycle, last_grant=2 -> host frame 16'h0721 first (host_ack one pulse), then RX frame.
REQ-038 rx_gain changes 6'h01->6'h02->6'h3f during RX frame in flight -> exactly one further RX frame 16'h097f.
REQ-039 spi_busy held low after spi_start -> spi_err pulse TIMEOUT cycles later; RX gain frame reissued after GAP.
REQ-040 reset_n low during WAIT_DONE -> outputs at reset values immediately; after release, both gain frames resent.
REQ-041 All three sources pending continuously -> grant order host, RX, TX, host, ... with no source starved.
